// File: rtl/digital_tube_scanner_if.sv
// Tube write channel from the IO manager: write strobe, register select and write data.
interface digital_tube_scanner_if;
  logic        iDoTubeWrite;
  logic [1:0]  iTubeAddress;
  logic [15:0] iTubeDataToWrite;

  modport master (output iDoTubeWrite, iTubeAddress, iTubeDataToWrite);
  modport slave  (input  iDoTubeWrite, iTubeAddress, iTubeDataToWrite);
endinterface

// File: rtl/digital_tube_scanner.sv
// Multiplexed seven-segment controller: scan, per-digit enable/blink/dp masks, leading-zero
// blanking. Defining TUBE_DECIMAL_EN adds the double-dabble decimal display mode.
module digital_tube_scanner #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 64
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  digital_tube_scanner_if.slave bus,
  output logic [DIGITS-1:0]     oTubesNotEnable,
  output logic [7:0]            oTubeShape
);
  localparam int NB = 4 * DIGITS;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam int SW = $clog2(NB);

  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        val_write;
  logic        dec_mode;

  assign wr_en     = bus.iDoTubeWrite;
  assign wr_addr   = bus.iTubeAddress;
  assign wr_data   = bus.iTubeDataToWrite;
  assign val_write = wr_en && ((wr_addr == 2'd0) || (wr_addr == 2'd1));

  logic [31:0]       val_q, val_d;
  logic              lzb_q, lzb_d;
  logic [DIGITS-1:0] en_mask_q, en_mask_d;
  logic [DIGITS-1:0] blink_mask_q, blink_mask_d;
  logic [DIGITS-1:0] dp_mask_q, dp_mask_d;
  logic [NB-1:0]     buf_q, buf_d;
  logic              ovf_q, ovf_d;

  logic [CW-1:0]     cyc_q, cyc_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              blink_on_q, blink_on_d;
  logic [DIGITS-1:0] nen_q, nen_d;
  logic [7:0]        shape_q, shape_d;

  always_comb begin
    val_d        = val_q;
    lzb_d        = lzb_q;
    en_mask_d    = en_mask_q;
    blink_mask_d = blink_mask_q;
    dp_mask_d    = dp_mask_q;
    if (wr_en) begin
      unique case (wr_addr)
        2'd0: val_d[15:0]  = wr_data;
        2'd1: val_d[31:16] = wr_data;
        2'd2: begin
          lzb_d     = wr_data[1];
          en_mask_d = wr_data[8 +: DIGITS];
        end
        default: begin
          blink_mask_d = wr_data[0 +: DIGITS];
          dp_mask_d    = wr_data[8 +: DIGITS];
        end
      endcase
    end
  end

`ifdef TUBE_DECIMAL_EN
  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_COMMIT} conv_state_e;

  conv_state_e   state_q, state_d;
  logic          dec_q, dec_d;
  logic [NB-1:0] bin_q, bin_d;
  logic [NB-1:0] bcd_q, bcd_d;
  logic [NB-1:0] bcd_adj;
  logic          carry_q, carry_d;
  logic [SW-1:0] bit_q, bit_d;
  logic          conv_start, conv_abort, conv_commit;

  assign dec_mode   = dec_q;
  assign conv_start = (val_write && dec_q) || (wr_en && (wr_addr == 2'd2) && wr_data[0]);
  assign conv_abort = wr_en && (wr_addr == 2'd2) && !wr_data[0];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                             : bcd_q[4*gi +: 4];
    end
  endgenerate

  // A bit leaving the top BCD digit means the value needs more than DIGITS decimal digits.
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    carry_d     = carry_q;
    bit_d       = bit_q;
    conv_commit = 1'b0;
    if (wr_en && (wr_addr == 2'd2)) dec_d = wr_data[0];
    unique case (state_q)
      CONV_SHIFT: begin
        bin_d   = {bin_q[NB-2:0], 1'b0};
        bcd_d   = {bcd_adj[NB-2:0], bin_q[NB-1]};
        carry_d = carry_q | bcd_adj[NB-1];
        bit_d   = bit_q + SW'(1);
        if (bit_q == SW'(NB - 1)) state_d = CONV_COMMIT;
      end
      CONV_COMMIT: begin
        conv_commit = !conv_start && !conv_abort;
        state_d     = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
    if (conv_start) begin
      state_d = CONV_SHIFT;
      bin_d   = val_d[NB-1:0];
      bcd_d   = '0;
      carry_d = 1'b0;
      bit_d   = '0;
    end else if (conv_abort) begin
      state_d = CONV_IDLE;
    end
  end

  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      state_q <= CONV_IDLE;
      dec_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      bit_q   <= bit_d;
    end
  end
`else
  assign dec_mode = 1'b0;
`endif

  always_comb begin
    buf_d = buf_q;
    ovf_d = ovf_q;
    if (val_write && !dec_mode) begin
      buf_d = val_d[NB-1:0];
      ovf_d = 1'b0;
    end
`ifdef TUBE_DECIMAL_EN
    if (conv_commit) begin
      buf_d = bcd_q;
      ovf_d = carry_q;
    end
`endif
  end

  // Scan position: cycle within digit, digit within frame, frame within blink half-period.
  always_comb begin
    cyc_d      = cyc_q + CW'(1);
    dig_d      = dig_q;
    frame_d    = frame_q;
    blink_on_d = blink_on_q;
    if (cyc_q == CW'(SCAN_DIV - 1)) begin
      cyc_d = '0;
      if (dig_q == DW'(DIGITS - 1)) begin
        dig_d = '0;
        if (frame_q == FW'(BLINK_SCANS - 1)) begin
          frame_d    = '0;
          blink_on_d = ~blink_on_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        dig_d = dig_q + DW'(1);
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s[6:0];
  endfunction

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] upper_zero;
  logic              suppress;
  logic [6:0]        cur_seg;

  genvar gd;
  generate
    for (gd = 0; gd < DIGITS; gd++) begin : g_digit
      assign nib[gd]        = buf_q[4*gd +: 4];
      assign upper_zero[gd] = ~|buf_q[NB-1:4*gd];
    end
  endgenerate

  // Overflow dashes are never treated as leading zeros.
  always_comb begin
    suppress = ~en_mask_q[dig_q]
             | (blink_mask_q[dig_q] & ~blink_on_q)
             | (lzb_q & (dig_q != '0) & upper_zero[dig_q] & ~ovf_q);
    cur_seg  = ovf_q ? 7'h3F : seg_of(nib[dig_q]);
    nen_d    = ~(DIGITS'(1) << dig_q);
    shape_d  = {~dp_mask_q[dig_q], cur_seg};
    if (suppress) begin
      nen_d   = '1;
      shape_d = 8'hFF;
    end
  end

  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      val_q        <= '0;
      lzb_q        <= 1'b0;
      en_mask_q    <= '1;
      blink_mask_q <= '0;
      dp_mask_q    <= '0;
      buf_q        <= '0;
      ovf_q        <= 1'b0;
      cyc_q        <= '0;
      dig_q        <= '0;
      frame_q      <= '0;
      blink_on_q   <= 1'b1;
      nen_q        <= '1;
      shape_q      <= 8'hFF;
    end else begin
      val_q        <= val_d;
      lzb_q        <= lzb_d;
      en_mask_q    <= en_mask_d;
      blink_mask_q <= blink_mask_d;
      dp_mask_q    <= dp_mask_d;
      buf_q        <= buf_d;
      ovf_q        <= ovf_d;
      cyc_q        <= cyc_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
      blink_on_q   <= blink_on_d;
      nen_q        <= nen_d;
      shape_q      <= shape_d;
    end
  end

  assign oTubesNotEnable = nen_q;
  assign oTubeShape      = shape_q;
endmodule

// File: tb/tb_digital_tube_scanner.sv
// Scoreboard bench for digital_tube_scanner: stimulus queues expected tube outputs per edge,
// a negedge monitor compares them as the scan presents each digit.
module tb_digital_tube_scanner;
  localparam int DIGITS      = 8;
  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] nen;
  logic [7:0] shape;

  digital_tube_scanner_if bus_if ();

  digital_tube_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_SCANS(BLINK_SCANS)
  ) dut (
    .iCpuClock(clk),
    .iCpuReset(rst),
    .bus(bus_if),
    .oTubesNotEnable(nen),
    .oTubeShape(shape)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] en;
    logic [7:0] sh;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   t0       = 0;
  int   max_edge = 0;
  int   checks   = 0;
  int   errors   = 0;
  bit   finished = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compares every queued expectation on the edge it names.
  always @(negedge clk) begin
    if (finished) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: edge %0d never checked (now %0d)", sb[i].name, sb[i].cyc, edge_cnt);
      end
      sb.delete();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= edge_cnt) begin
          checks++;
          if (sb[i].cyc < edge_cnt) begin
            errors++;
            $display("FAIL %s: expectation for edge %0d missed", sb[i].name, sb[i].cyc);
          end else if (nen !== sb[i].en || shape !== sb[i].sh) begin
            errors++;
            $display("FAIL %s @%0d: got en=%02h shape=%02h, expected en=%02h shape=%02h",
                     sb[i].name, edge_cnt, nen, shape, sb[i].en, sb[i].sh);
          end else begin
            $display("ok   %s @%0d: en=%02h shape=%02h", sb[i].name, edge_cnt, nen, shape);
          end
          sb.delete(i);
        end
      end
    end
  end

  function automatic int digit_at(int e);
    return ((e - t0) / SCAN_DIV) % DIGITS;
  endfunction

  function automatic int phase_at(int e);
    return (((e - t0) / (SCAN_DIV * DIGITS * BLINK_SCANS)) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int next_edge(int d, int from, int ph);
    for (int e = from; e < from + 1000; e++)
      if (digit_at(e) == d && (ph < 0 || phase_at(e) == ph)) return e;
    return from;
  endfunction

  task automatic expect_at(input int e, input logic [7:0] en, input logic [7:0] sh,
                           input string name);
    exp_t x;
    x.cyc = e; x.en = en; x.sh = sh; x.name = name;
    sb.push_back(x);
    if (e > max_edge) max_edge = e;
  endtask

  // A shape of FF denotes a suppressed digit (all enables high).
  task automatic expect_digit(input int d, input int from, input int ph, input logic [7:0] sh,
                              input string name);
    logic [7:0] en;
    en = (sh == 8'hFF) ? 8'hFF : 8'(~(8'd1 << d));
    expect_at(next_edge(d, from, ph), en, sh, name);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_if.iDoTubeWrite     = 1'b1;
    bus_if.iTubeAddress     = a;
    bus_if.iTubeDataToWrite = d;
    @(negedge clk);
    bus_if.iDoTubeWrite     = 1'b0;
  endtask

  task automatic drain;
    while (edge_cnt <= max_edge) @(negedge clk);
  endtask

  initial begin
    logic [7:0] lzb_tab [8];
    logic [7:0] old_tab [8];
    int w, a, e, f;
    lzb_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    old_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    bus_if.iDoTubeWrite     = 1'b0;
    bus_if.iTubeAddress     = 2'd0;
    bus_if.iTubeDataToWrite = 16'h0000;
    rst = 1'b1;
    expect_at(2, 8'hFF, 8'hFF, "rst_hold");
    expect_at(4, 8'hFF, 8'hFF, "rst_hold");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    t0  = edge_cnt + 1;
    expect_at(t0,      8'hFE, 8'hC0, "rel_d0_first");
    expect_at(t0 + 3,  8'hFE, 8'hC0, "rel_d0_last");
    expect_at(t0 + 4,  8'hFD, 8'hC0, "rel_d1_first");
    expect_at(t0 + 31, 8'h7F, 8'hC0, "rel_d7_last");
    expect_at(t0 + 32, 8'hFE, 8'hC0, "rel_frame_wrap");
    drain();

    wr(2'd0, 16'h1234);
    wr(2'd1, 16'hABCD);
    f = edge_cnt + 1;
    expect_digit(0, f, -1, 8'h99, "hex_d0");
    expect_digit(1, f, -1, 8'hB0, "hex_d1");
    expect_digit(3, f, -1, 8'hF9, "hex_d3");
    expect_digit(4, f, -1, 8'hA1, "hex_d4");
    expect_digit(7, f, -1, 8'h88, "hex_d7");
    drain();

`ifdef TUBE_DECIMAL_EN
    wr(2'd0, 16'h9999);
    wr(2'd1, 16'h9999);
    wr(2'd2, 16'hFF03);
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h04D2);
    w = edge_cnt;
    e = w + 33;
    expect_at(e, 8'(~(8'd1 << digit_at(e))), 8'h90, "dec_old_buffer");
    e = w + 34;
    expect_digit(digit_at(e), e, -1, lzb_tab[digit_at(e)], "dec_commit_edge");
    for (int d = 0; d < 8; d++) expect_digit(d, w + 34, -1, lzb_tab[d], "dec_lzb_digit");
    drain();

    wr(2'd2, 16'hFF01);
    f = edge_cnt + 1;
    expect_digit(3, f, -1, 8'hF9, "dec_nolzb_d3");
    for (int d = 4; d < 8; d++) expect_digit(d, f, -1, 8'hC0, "dec_nolzb_zero");
    drain();

    wr(2'd1, 16'h05F5);
    a = edge_cnt;
    repeat (8) @(negedge clk);
    wr(2'd0, 16'hE100);
    w = edge_cnt;
    expect_at(a + 34, 8'(~(8'd1 << digit_at(a + 34))), old_tab[digit_at(a + 34)], "ovf_restarted");
    expect_at(w + 33, 8'(~(8'd1 << digit_at(w + 33))), old_tab[digit_at(w + 33)], "ovf_pre_commit");
    expect_at(w + 34, 8'(~(8'd1 << digit_at(w + 34))), 8'hBF, "ovf_commit_edge");
    expect_digit(0, w + 34, -1, 8'hBF, "ovf_d0");
    expect_digit(7, w + 34, -1, 8'hBF, "ovf_d7");
    drain();
`else
    wr(2'd2, 16'hFF03);
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h04D2);
    f = edge_cnt + 1;
    expect_digit(0, f, -1, 8'hA4, "hexlzb_d0");
    expect_digit(1, f, -1, 8'hA1, "hexlzb_d1");
    expect_digit(2, f, -1, 8'h99, "hexlzb_d2");
    expect_digit(3, f, -1, 8'hFF, "hexlzb_d3_blank");
    expect_digit(7, f, -1, 8'hFF, "hexlzb_d7_blank");
    drain();
`endif

    wr(2'd2, 16'hFF00);
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h0000);
    expect_digit(5, edge_cnt + 1, -1, 8'hC0, "clear_d5");
    drain();

    wr(2'd2, 16'h7F00);
    f = edge_cnt + 1;
    expect_digit(7, f, -1, 8'hFF, "enmask_d7_off");
    expect_digit(6, f, -1, 8'hC0, "enmask_d6_on");
    drain();
    wr(2'd2, 16'hFF00);

    wr(2'd3, 16'h0101);
    f = edge_cnt + 1;
    expect_digit(0, f, 1, 8'h40, "blink_d0_on_dp");
    expect_digit(0, f, 0, 8'hFF, "blink_d0_off");
    expect_digit(1, f, 0, 8'hC0, "blink_d1_unaffected");
    drain();

    wr(2'd2, 16'hFF01);
    wr(2'd0, 16'h1234);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    expect_at(edge_cnt + 1, 8'hFF, 8'hFF, "rst_mid_hold");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0  = edge_cnt + 1;
    expect_at(t0,     8'hFE, 8'hC0, "rst_mid_d0");
    expect_at(t0 + 4, 8'hFD, 8'hC0, "rst_mid_d1");
    expect_digit(3, t0 + 32, -1, 8'hC0, "rst_mid_d3_late");
    expect_at(t0 + 32, 8'hFE, 8'hC0, "rst_mid_d0_late");
    drain();

    finished = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end
endmodule
